hex_card_reader: RTL and testbench
==================================

# hex_card_reader

Reads back the six active-low seven-segment card displays (player HEX0–HEX2, dealer HEX3–HEX5) and recovers the 4-bit card codes they show, the inverse of the card-to-segment encoder. Each digit must hold a stable pattern for a set number of cycles before it is decoded. Results stream out one digit at a time over a valid/ready handshake. It sits beside the display path as a self-check and loopback block for the baccarat datapath.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required to accept a digit; legal range 2..15.
- TIMEOUT_CYCLES, 64: maximum cycles spent in SETTLE per digit before forcing an error result; must exceed STABLE_CYCLES.
- CLOCK_50  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; returns block to IDLE.
- start  in  1  one-cycle scan request; ignored unless in IDLE.
- HEX0..HEX5  in  7 each  active-low segment patterns, bit 6 = segment g … bit 0 = segment a.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_digit  out  3  display index 0..5 of the result.
- out_card  out  4  card code: 0 blank, 1 A, 2..10, 11 J, 12 Q, 13 K, 4'hF error.
- out_err  out  1  result is invalid (timeout or unrecognised pattern).
- err_seen  out  1  sticky; set by any error result in the current scan, cleared by an accepted start.
- done  out  1  one-cycle pulse after the sixth result is accepted.

## Operation
- Decode map (pattern→code): 1111111→0, 0001000→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9, 1000000→10, 1100001→11, 0011000→12, 0001001→13. Any other pattern → code 4'hF, out_err=1.
- Internal registers: idx (3b), cap (7b captured pattern), stab (4b), tmo (counter sized to TIMEOUT_CYCLES).
- IDLE: when start=1, set idx←0, cap←HEX0, stab←1, tmo←0, err_seen←0, then go to SETTLE.
- SETTLE: on each edge, tmo←tmo+1.
  - If HEX[idx]==cap and stab+1==STABLE_CYCLES, latch out_card/out_err←decode(cap), go to EMIT.
  - Else if HEX[idx]==cap, stab←stab+1.
  - Else cap←HEX[idx], stab←1.
  - If tmo+1==TIMEOUT_CYCLES and the pattern is not accepted on this edge, latch out_card←4'hF, out_err←1, go to EMIT. If acceptance and timeout fall on the same edge, acceptance wins.
- EMIT: out_valid=1. out_digit, out_card and out_err hold steady until out_ready=1 is sampled.
  - On handshake with idx<5: idx←idx+1, cap←HEX[idx+1], stab←1, tmo←0, go to SETTLE.
  - On handshake with idx==5: go to DONE.
  - On handshake with out_err=1: err_seen←1.
- DONE: done=1 for one cycle, then go to IDLE.
- start during any non-IDLE state has no effect.

## Timing
- Reset values: state IDLE, busy 0, out_valid 0, out_digit 0, out_card 0, out_err 0, err_seen 0, done 0.
- Reset asserted mid-scan aborts the scan on that edge; no further results or done pulse are produced.
- With static inputs, out_valid rises STABLE_CYCLES−1 edges after the start edge.
- Each later digit becomes valid STABLE_CYCLES−1 edges after the previous handshake.
- With out_ready held at 1, a full scan takes 6·STABLE_CYCLES edges from start to the final handshake. done asserts in the following cycle and busy drops one cycle after that.
- A pattern that changes on the last settle edge restarts stab at 1; no partial credit is kept.
- A timeout result appears exactly TIMEOUT_CYCLES edges after entry to SETTLE.
- out_ready is ignored outside EMIT.

## Structure
- Shared card_pkg holds:
  - the 14 segment-pattern localparams, shared with the encoder so both ends use one table;
  - a card_t typedef (logic [3:0]);
  - the CARD_ERR constant (4'hF);
  - the state enum {IDLE, SETTLE, EMIT, DONE}.
- Sub-module seg7_card_decode: purely combinational, pattern[6:0] → {code[3:0], invalid}. The block instantiates it once on cap.
- Mux HEX0..HEX5 by idx; the FSM and counters stay in hex_card_reader.

## Test plan
- Static HEX0..HEX5 = A,2,3,J,Q,K patterns; start; out_ready=1 → codes 1,2,3,11,12,13 on digits 0..5, out_err=0, done at edge 24 (STABLE=4), err_seen=0.
- HEX2 = 1010101 (unrecognised), all others blank → digit 2 returns 4'hF with out_err=1, err_seen=1 after done; the remaining digits return 0.
- HEX0 toggles between 8 and 9 patterns every 2 cycles → timeout: digit 0 valid at edge 64 with 4'hF, out_err=1.
- HEX1 glitches once mid-settle, then holds at 7 → digit 1 is accepted STABLE_CYCLES−1 edges after the glitch clears, code 7.
- out_ready held low for 10 cycles in EMIT while HEX0 changes → out_card and out_digit stay frozen; a start pulse mid-scan is ignored.
- reset asserted while in SETTLE on digit 3 → all outputs return to reset values on the next edge; a fresh start rescans from digit 0.

Source files
------------

// File: rtl/card_pkg.sv
// Shared card definitions: segment patterns (active-low, bit 6 = g ... bit 0 = a),
// card code type and reader state encoding.
package card_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_ERR = 4'hF;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_10    = 7'b1000000;
  localparam logic [6:0] SEG_J     = 7'b1100001;
  localparam logic [6:0] SEG_Q     = 7'b0011000;
  localparam logic [6:0] SEG_K     = 7'b0001001;

  typedef enum logic [1:0] {IDLE, SETTLE, EMIT, DONE} state_t;

endpackage

// File: rtl/seg7_card_decode.sv
// Combinational inverse of the card-to-segment encoder; unknown patterns
// yield CARD_ERR with invalid_o set.
module seg7_card_decode
  import card_pkg::*;
(
  input  logic [6:0] pattern_i,
  output card_t      code_o,
  output logic       invalid_o
);

  always_comb begin
    code_o    = CARD_ERR;
    invalid_o = 1'b0;
    case (pattern_i)
      SEG_BLANK: code_o = 4'd0;
      SEG_A:     code_o = 4'd1;
      SEG_2:     code_o = 4'd2;
      SEG_3:     code_o = 4'd3;
      SEG_4:     code_o = 4'd4;
      SEG_5:     code_o = 4'd5;
      SEG_6:     code_o = 4'd6;
      SEG_7:     code_o = 4'd7;
      SEG_8:     code_o = 4'd8;
      SEG_9:     code_o = 4'd9;
      SEG_10:    code_o = 4'd10;
      SEG_J:     code_o = 4'd11;
      SEG_Q:     code_o = 4'd12;
      SEG_K:     code_o = 4'd13;
      default:   invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/hex_card_reader.sv
// Scans the six card displays in order, debounces each digit, decodes it and
// streams {digit, card, err} results over a valid/ready handshake.
module hex_card_reader
  import card_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] HEX0,
  input  logic [6:0] HEX1,
  input  logic [6:0] HEX2,
  input  logic [6:0] HEX3,
  input  logic [6:0] HEX4,
  input  logic [6:0] HEX5,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_digit,
  output card_t      out_card,
  output logic       out_err,
  output logic       err_seen,
  output logic       done
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]    STABLE_LAST = 4'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES);

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [6:0]    cap_q, cap_d;
  logic [3:0]    stab_q, stab_d;
  logic [TW-1:0] tmo_q, tmo_d;
  card_t         outCard_q, outCard_d;
  logic          outErr_q, outErr_d;
  logic          errSeen_q, errSeen_d;

  logic [6:0]    hexCur, hexNext;
  card_t         decCode;
  logic          decInvalid;
  logic [3:0]    stabInc;
  logic [TW-1:0] tmoInc;
  logic          samePat, accept, expire;

  // hexCur is the digit being settled; hexNext is the one loaded on handshake.
  always_comb begin
    hexCur  = HEX0;
    hexNext = HEX5;
    case (idx_q)
      3'd0: begin hexCur = HEX0; hexNext = HEX1; end
      3'd1: begin hexCur = HEX1; hexNext = HEX2; end
      3'd2: begin hexCur = HEX2; hexNext = HEX3; end
      3'd3: begin hexCur = HEX3; hexNext = HEX4; end
      3'd4: begin hexCur = HEX4; hexNext = HEX5; end
      3'd5: begin hexCur = HEX5; hexNext = HEX5; end
      default: begin hexCur = HEX0; hexNext = HEX5; end
    endcase
  end

  seg7_card_decode uDecode (
    .pattern_i (cap_q),
    .code_o    (decCode),
    .invalid_o (decInvalid)
  );

  assign stabInc = stab_q + 4'd1;
  assign tmoInc  = tmo_q + 1'b1;
  assign samePat = (hexCur == cap_q);
  assign accept  = samePat && (stabInc == STABLE_LAST);
  assign expire  = (tmoInc == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cap_d     = cap_q;
    stab_d    = stab_q;
    tmo_d     = tmo_q;
    outCard_d = outCard_q;
    outErr_d  = outErr_q;
    errSeen_d = errSeen_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d     = 3'd0;
          cap_d     = HEX0;
          stab_d    = 4'd1;
          tmo_d     = '0;
          errSeen_d = 1'b0;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        tmo_d = tmoInc;
        // Acceptance takes priority over a timeout landing on the same edge.
        if (accept) begin
          outCard_d = decCode;
          outErr_d  = decInvalid;
          state_d   = EMIT;
        end else begin
          if (samePat) begin
            stab_d = stabInc;
          end else begin
            cap_d  = hexCur;
            stab_d = 4'd1;
          end
          if (expire) begin
            outCard_d = CARD_ERR;
            outErr_d  = 1'b1;
            state_d   = EMIT;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (outErr_q) errSeen_d = 1'b1;
          if (idx_q == 3'd5) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            cap_d   = hexNext;
            stab_d  = 4'd1;
            tmo_d   = '0;
            state_d = SETTLE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      cap_q     <= 7'd0;
      stab_q    <= 4'd0;
      tmo_q     <= '0;
      outCard_q <= 4'd0;
      outErr_q  <= 1'b0;
      errSeen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cap_q     <= cap_d;
      stab_q    <= stab_d;
      tmo_q     <= tmo_d;
      outCard_q <= outCard_d;
      outErr_q  <= outErr_d;
      errSeen_q <= errSeen_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == EMIT);
  assign done      = (state_q == DONE);
  assign out_digit = idx_q;
  assign out_card  = outCard_q;
  assign out_err   = outErr_q;
  assign err_seen  = errSeen_q;

endmodule

// File: tb/tb_hex_card_reader.sv
// Directed bench for hex_card_reader: table-driven full scans plus hand-written
// timeout, glitch, back-pressure and mid-scan reset sequences.
module tb_hex_card_reader;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 64;

  localparam logic [6:0] P_BLANK = 7'b1111111;
  localparam logic [6:0] P_A  = 7'b0001000;
  localparam logic [6:0] P_2  = 7'b0100100;
  localparam logic [6:0] P_3  = 7'b0110000;
  localparam logic [6:0] P_4  = 7'b0011001;
  localparam logic [6:0] P_5  = 7'b0010010;
  localparam logic [6:0] P_6  = 7'b0000010;
  localparam logic [6:0] P_7  = 7'b1111000;
  localparam logic [6:0] P_8  = 7'b0000000;
  localparam logic [6:0] P_9  = 7'b0010000;
  localparam logic [6:0] P_10 = 7'b1000000;
  localparam logic [6:0] P_J  = 7'b1100001;
  localparam logic [6:0] P_Q  = 7'b0011000;
  localparam logic [6:0] P_K  = 7'b0001001;

  typedef struct packed {
    logic [5:0][6:0] hex;
    logic [5:0][3:0] code;
    logic            errSeen;
  } scan_vec_t;

  logic       CLOCK_50 = 1'b0;
  logic       reset, start, out_ready;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic       busy, out_valid, out_err, err_seen, done;
  logic [2:0] out_digit;
  logic [3:0] out_card;

  int checks = 0;
  int errors = 0;
  scan_vec_t vecs[4];

  always #5 CLOCK_50 = ~CLOCK_50;

  hex_card_reader #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .start    (start),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_digit(out_digit),
    .out_card (out_card),
    .out_err  (out_err),
    .err_seen (err_seen),
    .done     (done)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic setHex(input logic [5:0][6:0] h);
    HEX0 = h[0]; HEX1 = h[1]; HEX2 = h[2];
    HEX3 = h[3]; HEX4 = h[4]; HEX5 = h[5];
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input scan_vec_t v);
    setHex(v.hex);
    out_ready = 1'b1;
    pulseStart();
  endtask

  task automatic resetPulse();
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
  endtask

  task automatic waitValid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge CLOCK_50);
      n++;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " out_valid"}, out_valid, 0);
    checkOutput({tag, " out_digit"}, out_digit, 0);
    checkOutput({tag, " out_card"}, out_card, 0);
    checkOutput({tag, " out_err"}, out_err, 0);
    checkOutput({tag, " err_seen"}, err_seen, 0);
    checkOutput({tag, " done"}, done, 0);
  endtask

  task automatic runScan(input scan_vec_t v, input int tag);
    int n;
    applyStimulus(v);
    for (int d = 0; d < 6; d++) begin
      waitValid(n);
      checkOutput($sformatf("v%0d d%0d latency", tag, d), n, STABLE - 1);
      checkOutput($sformatf("v%0d d%0d digit", tag, d), out_digit, d);
      checkOutput($sformatf("v%0d d%0d card", tag, d), out_card, v.code[d]);
      checkOutput($sformatf("v%0d d%0d err", tag, d), out_err, (v.code[d] == 4'hF));
      @(negedge CLOCK_50);
    end
    checkOutput($sformatf("v%0d done pulse", tag), done, 1);
    checkOutput($sformatf("v%0d busy in done", tag), busy, 1);
    checkOutput($sformatf("v%0d err_seen", tag), err_seen, v.errSeen);
    @(negedge CLOCK_50);
    checkOutput($sformatf("v%0d done cleared", tag), done, 0);
    checkOutput($sformatf("v%0d busy cleared", tag), busy, 0);
  endtask

  initial begin
    int n;
    scan_vec_t v;

    vecs[0].hex  = {P_K, P_Q, P_J, P_3, P_2, P_A};
    vecs[0].code = {4'd13, 4'd12, 4'd11, 4'd3, 4'd2, 4'd1};
    vecs[0].errSeen = 1'b0;
    vecs[1].hex  = {P_BLANK, P_BLANK, P_BLANK, 7'b1010101, P_BLANK, P_BLANK};
    vecs[1].code = {4'd0, 4'd0, 4'd0, 4'hF, 4'd0, 4'd0};
    vecs[1].errSeen = 1'b1;
    vecs[2].hex  = {P_9, P_8, P_7, P_6, P_5, P_4};
    vecs[2].code = {4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4};
    vecs[2].errSeen = 1'b0;
    vecs[3].hex  = {P_K, P_6, 7'b0000001, P_8, P_BLANK, P_10};
    vecs[3].code = {4'd13, 4'd6, 4'hF, 4'd8, 4'd0, 4'd10};
    vecs[3].errSeen = 1'b1;

    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    setHex({6{P_BLANK}});
    repeat (2) @(negedge CLOCK_50);
    checkResetValues("reset");
    reset = 1'b0;
    @(negedge CLOCK_50);

    for (int i = 0; i < 4; i++) runScan(vecs[i], i);

    // Timeout: HEX0 alternates 8/9 every two cycles so it never settles.
    setHex({6{P_BLANK}});
    HEX0 = P_8;
    out_ready = 1'b0;
    pulseStart();
    n = 0;
    while (out_valid !== 1'b1 && n < 80) begin
      @(negedge CLOCK_50);
      n++;
      if (n % 2 == 1) HEX0 = (HEX0 == P_8) ? P_9 : P_8;
    end
    checkOutput("timeout edge", n, TIMEOUT);
    checkOutput("timeout digit", out_digit, 0);
    checkOutput("timeout card", out_card, 4'hF);
    checkOutput("timeout err", out_err, 1);
    checkOutput("timeout err_seen before ack", err_seen, 0);
    out_ready = 1'b1;
    @(negedge CLOCK_50);
    checkOutput("timeout err_seen after ack", err_seen, 1);
    checkOutput("timeout next digit settling", out_valid, 0);
    resetPulse();

    // Glitch on HEX1 mid-settle restarts the stability count.
    setHex({6{P_BLANK}});
    HEX1 = P_7;
    out_ready = 1'b1;
    pulseStart();
    waitValid(n);
    checkOutput("glitch d0 card", out_card, 0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    HEX1 = P_8;
    @(negedge CLOCK_50);
    HEX1 = P_7;
    @(negedge CLOCK_50);
    checkOutput("glitch not yet valid", out_valid, 0);
    waitValid(n);
    checkOutput("glitch latency", n, STABLE - 1);
    checkOutput("glitch digit", out_digit, 1);
    checkOutput("glitch card", out_card, 7);
    checkOutput("glitch err", out_err, 0);
    resetPulse();

    // Back-pressure: result frozen while HEX0 changes; mid-scan start ignored.
    setHex({6{P_5}});
    out_ready = 1'b0;
    pulseStart();
    waitValid(n);
    checkOutput("hold latency", n, STABLE - 1);
    for (int i = 0; i < 10; i++) begin
      HEX0  = (i % 2 == 1) ? P_8 : P_K;
      start = (i == 5);
      @(negedge CLOCK_50);
      checkOutput($sformatf("hold %0d valid", i), out_valid, 1);
      checkOutput($sformatf("hold %0d digit", i), out_digit, 0);
      checkOutput($sformatf("hold %0d card", i), out_card, 5);
    end
    start = 1'b0;
    HEX0 = P_5;
    out_ready = 1'b1;
    @(negedge CLOCK_50);
    waitValid(n);
    checkOutput("hold next latency", n, STABLE - 1);
    checkOutput("hold next digit", out_digit, 1);
    checkOutput("hold next card", out_card, 5);
    resetPulse();

    // Reset while settling digit 3 aborts the scan; a new start rescans.
    v = vecs[0];
    v.hex[0] = 7'b1010101;
    applyStimulus(v);
    waitValid(n);
    checkOutput("abort d0 card", out_card, 4'hF);
    @(negedge CLOCK_50);
    checkOutput("abort err_seen set", err_seen, 1);
    for (int d = 1; d < 3; d++) begin
      waitValid(n);
      checkOutput($sformatf("abort d%0d card", d), out_card, v.code[d]);
      @(negedge CLOCK_50);
    end
    @(negedge CLOCK_50);
    checkOutput("abort busy before reset", busy, 1);
    checkOutput("abort digit before reset", out_digit, 3);
    reset = 1'b1;
    @(negedge CLOCK_50);
    checkResetValues("abort");
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLOCK_50);
      checkOutput($sformatf("abort quiet %0d", i), {29'd0, out_valid, done, busy}, 0);
    end
    runScan(vecs[0], 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
